// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: IFU request/response, LSU request/response
// and the shared memory port. slave = arbiter view, master = environment view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [2:0]        lsu_memop;
  logic [DATA_W-1:0] lsu_wdata;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_memop, lsu_wdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
    output mem_req_valid, mem_addr, mem_wen, mem_size, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_memop, lsu_wdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_size, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding IFU/LSU arbiter onto one valid/ready
// memory port, with load sign/zero extension on the LSU return path.
// Optional macro MEM_ARB_RR_EN: round-robin grant instead of fixed LSU priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q;          // 0 = IFU, 1 = LSU
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        memop_q;
  logic              err_q;
  logic [DATA_W-1:0] ifu_rdata_q, lsu_rdata_q;
  logic [DATA_W-1:0] ext_data;

  logic grant_lsu, lsu_legal;
  logic ifu_ready, lsu_ready, ifu_hs, lsu_hs;
  logic mem_req_valid, ifu_resp_valid, lsu_resp_valid, lsu_err;

  assign ifu_hs = ifu_ready && bus.ifu_req_valid;
  assign lsu_hs = lsu_ready && bus.lsu_req_valid;

`ifdef MEM_ARB_RR_EN
  logic last_lsu_q;
  // On a tie the side that did not win last time is granted.
  assign grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu_q);

  // Remember who won the last accepted request; starts as "LSU last".
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  last_lsu_q <= 1'b1;
    else if (ifu_hs || lsu_hs) last_lsu_q <= lsu_hs;
  end
`else
  assign grant_lsu = bus.lsu_req_valid;
`endif

  // Legal memops: b, h, w, bu, hu.
  always_comb begin
    lsu_legal = 1'b0;
    case (bus.lsu_memop)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: lsu_legal = 1'b1;
      default:                                 lsu_legal = 1'b0;
    endcase
  end

  // Load extension of the returned data; stores return 0, fetches raw data.
  always_comb begin
    ext_data = bus.mem_rdata;
    if (owner_q) begin
      if (wen_q) ext_data = '0;
      else begin
        case (memop_q)
          3'b000:  ext_data = {{(DATA_W-8){bus.mem_rdata[7]}},   bus.mem_rdata[7:0]};
          3'b001:  ext_data = {{(DATA_W-16){bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
          3'b100:  ext_data = {{(DATA_W-8){1'b0}},               bus.mem_rdata[7:0]};
          3'b101:  ext_data = {{(DATA_W-16){1'b0}},              bus.mem_rdata[15:0]};
          default: ext_data = bus.mem_rdata;
        endcase
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state, grant/ready and response strobes.
  always_comb begin
    state_d        = state_q;
    ifu_ready      = 1'b0;
    lsu_ready      = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_err        = 1'b0;
    case (state_q)
      IDLE: begin
        lsu_ready = grant_lsu;
        ifu_ready = bus.ifu_req_valid && !grant_lsu;
        if (lsu_ready)      state_d = lsu_legal ? REQ : RESP;
        else if (ifu_ready) state_d = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = WAIT;
      end
      WAIT: if (bus.mem_resp_valid) state_d = RESP;
      RESP: begin
        ifu_resp_valid = !owner_q;
        lsu_resp_valid = owner_q;
        lsu_err        = owner_q && err_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the accepted request and capture the response data for the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      size_q      <= 2'd0;
      wdata_q     <= '0;
      memop_q     <= 3'd0;
      err_q       <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      if (lsu_hs) begin
        owner_q <= 1'b1;
        addr_q  <= bus.lsu_addr;
        wen_q   <= bus.lsu_wen;
        size_q  <= lsu_legal ? bus.lsu_memop[1:0] : 2'd0;
        wdata_q <= bus.lsu_wdata;
        memop_q <= bus.lsu_memop;
        err_q   <= !lsu_legal;
        if (!lsu_legal) lsu_rdata_q <= '0;
      end else if (ifu_hs) begin
        owner_q <= 1'b0;
        addr_q  <= bus.ifu_addr;
        wen_q   <= 1'b0;
        size_q  <= 2'd2;
        wdata_q <= '0;
        memop_q <= 3'b010;
        err_q   <= 1'b0;
      end
      if (state_q == WAIT && bus.mem_resp_valid) begin
        if (owner_q) lsu_rdata_q <= ext_data;
        else         ifu_rdata_q <= ext_data;
      end
    end
  end

  assign bus.ifu_req_ready  = ifu_ready;
  assign bus.lsu_req_ready  = lsu_ready;
  assign bus.ifu_resp_valid = ifu_resp_valid;
  assign bus.lsu_resp_valid = lsu_resp_valid;
  assign bus.lsu_err        = lsu_err;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.mem_req_valid  = mem_req_valid;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_size       = size_q;
  assign bus.mem_wdata      = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, load extension, stalled store,
// arbitration (fixed or round-robin per MEM_ARB_RR_EN), illegal memop,
// and reset in the middle of a transaction.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, ".ifu_ready"},  {31'd0, bus.ifu_req_ready},  32'd0);
    chk({tag, ".lsu_ready"},  {31'd0, bus.lsu_req_ready},  32'd0);
    chk({tag, ".ifu_resp"},   {31'd0, bus.ifu_resp_valid}, 32'd0);
    chk({tag, ".lsu_resp"},   {31'd0, bus.lsu_resp_valid}, 32'd0);
    chk({tag, ".lsu_err"},    {31'd0, bus.lsu_err},        32'd0);
    chk({tag, ".ifu_rdata"},  bus.ifu_rdata,               32'd0);
    chk({tag, ".lsu_rdata"},  bus.lsu_rdata,               32'd0);
    chk({tag, ".mem_valid"},  {31'd0, bus.mem_req_valid},  32'd0);
    chk({tag, ".mem_addr"},   bus.mem_addr,                32'd0);
    chk({tag, ".mem_ctl"},    {29'd0, bus.mem_wen, bus.mem_size}, 32'd0);
    chk({tag, ".mem_wdata"},  bus.mem_wdata,               32'd0);
  endtask

  // IFU fetch with memory ready immediately and responding one cycle later.
  task automatic ifu_fetch(input string tag, input logic [31:0] addr, input logic [31:0] rd);
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = addr; bus.mem_req_ready = 1'b1;
    #1;
    chk({tag, ".ifu_ready"}, {31'd0, bus.ifu_req_ready}, 32'd1);
    tick();                                      // accept edge N passed
    bus.ifu_req_valid = 1'b0; bus.ifu_addr = 32'hFFFF_FFFF;
    #1;
    chk({tag, ".mem_valid"}, {31'd0, bus.mem_req_valid}, 32'd1);
    chk({tag, ".mem_addr"},  bus.mem_addr, addr);
    chk({tag, ".mem_ctl"},   {29'd0, bus.mem_wen, bus.mem_size}, 32'd2);
    tick();                                      // N+2, WAIT
    chk({tag, ".mem_valid_off"}, {31'd0, bus.mem_req_valid}, 32'd0);
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = rd;
    tick();                                      // N+3, RESP
    bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0BAD_0BAD;
    #1;
    chk({tag, ".ifu_resp"},  {31'd0, bus.ifu_resp_valid}, 32'd1);
    chk({tag, ".ifu_rdata"}, bus.ifu_rdata, rd);
    chk({tag, ".lsu_resp"},  {31'd0, bus.lsu_resp_valid}, 32'd0);
    tick();                                      // N+4, IDLE
    chk({tag, ".ifu_resp_off"}, {31'd0, bus.ifu_resp_valid}, 32'd0);
    chk({tag, ".ifu_rdata_hold"}, bus.ifu_rdata, rd);
  endtask

  // LSU load with memory ready immediately and responding one cycle later.
  task automatic lsu_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] rd, input logic [31:0] exp);
    bus.lsu_req_valid = 1'b1; bus.lsu_addr = addr; bus.lsu_wen = 1'b0;
    bus.lsu_memop = op; bus.mem_req_ready = 1'b1;
    #1;
    chk({tag, ".lsu_ready"}, {31'd0, bus.lsu_req_ready}, 32'd1);
    tick();
    bus.lsu_req_valid = 1'b0;
    #1;
    chk({tag, ".mem_addr"}, bus.mem_addr, addr);
    chk({tag, ".mem_size"}, {30'd0, bus.mem_size}, {30'd0, size});
    tick();
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = rd;
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    chk({tag, ".lsu_resp"},  {31'd0, bus.lsu_resp_valid}, 32'd1);
    chk({tag, ".lsu_rdata"}, bus.lsu_rdata, exp);
    chk({tag, ".lsu_err"},   {31'd0, bus.lsu_err}, 32'd0);
    tick();
  endtask

  initial begin
    logic exp_lsu;
    rst = 1'b1;
    bus.ifu_req_valid = 1'b0; bus.ifu_addr = '0;
    bus.lsu_req_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_wen = 1'b0;
    bus.lsu_memop = 3'b010; bus.lsu_wdata = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    ifu_fetch("fetch0", 32'h8000_0000, 32'h0000_0413);

    lsu_load("lb",  3'b000, 32'h8000_1003, 2'd0, 32'hFFFF_FF80, 32'hFFFF_FF80);
    lsu_load("lbu", 3'b100, 32'h8000_1003, 2'd0, 32'h1234_5680, 32'h0000_0080);
    lsu_load("lh",  3'b001, 32'h8000_1002, 2'd1, 32'h0000_8001, 32'hFFFF_8001);
    lsu_load("hu",  3'b101, 32'h8000_1002, 2'd1, 32'hABCD_8001, 32'h0000_8001);
    lsu_load("lw",  3'b010, 32'h8000_1000, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Store stalled by mem_req_ready low for 3 cycles; payload changes after accept.
    bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_2000; bus.lsu_wen = 1'b1;
    bus.lsu_memop = 3'b010; bus.lsu_wdata = 32'hDEAD_BEEF; bus.mem_req_ready = 1'b0;
    #1;
    chk("sw.lsu_ready", {31'd0, bus.lsu_req_ready}, 32'd1);
    tick();
    bus.lsu_req_valid = 1'b0; bus.lsu_addr = 32'h1111_1111; bus.lsu_wdata = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      bus.mem_resp_valid = (i == 1);             // stray response in REQ is dropped
      bus.mem_rdata = 32'h7777_7777;
      bus.mem_req_ready = (i == 3);
      #1;
      chk("sw.mem_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      chk("sw.mem_addr",  bus.mem_addr,  32'h8000_2000);
      chk("sw.mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("sw.mem_ctl",   {29'd0, bus.mem_wen, bus.mem_size}, 32'd6);
      tick();
    end
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h5555_5555;
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("sw.lsu_resp",  {31'd0, bus.lsu_resp_valid}, 32'd1);
    chk("sw.lsu_rdata", bus.lsu_rdata, 32'd0);
    tick();
    bus.lsu_wen = 1'b0;

    // Both sides requesting continuously for 4 grants.
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h0000_0100;
    bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h0000_0200; bus.lsu_memop = 3'b010;
    bus.mem_req_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_RR_EN
      exp_lsu = (g % 2) == 1;
`else
      exp_lsu = 1'b1;
`endif
      #1;
      chk("arb.lsu_ready", {31'd0, bus.lsu_req_ready}, {31'd0, exp_lsu});
      chk("arb.ifu_ready", {31'd0, bus.ifu_req_ready}, {31'd0, !exp_lsu});
      tick();
      chk("arb.mem_addr", bus.mem_addr, exp_lsu ? 32'h0000_0200 : 32'h0000_0100);
      chk("arb.no_ready", {30'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 32'd0);
      tick();
      bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hA000_0000 + g;
      tick();
      bus.mem_resp_valid = 1'b0;
      #1;
      chk("arb.resp", {30'd0, bus.lsu_resp_valid, bus.ifu_resp_valid},
          exp_lsu ? 32'd2 : 32'd1);
      tick();
    end
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0; bus.mem_req_ready = 1'b0;

    // Illegal memop: accepted, no memory access, error response next cycle.
    bus.lsu_req_valid = 1'b1; bus.lsu_memop = 3'b011; bus.lsu_addr = 32'h8000_3000;
    #1;
    chk("ill.lsu_ready", {31'd0, bus.lsu_req_ready}, 32'd1);
    tick();
    bus.lsu_req_valid = 1'b0;
    #1;
    chk("ill.mem_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("ill.resp_err",  {30'd0, bus.lsu_resp_valid, bus.lsu_err}, 32'd3);
    chk("ill.lsu_rdata", bus.lsu_rdata, 32'd0);
    tick();
    chk("ill.resp_off",  {30'd0, bus.lsu_resp_valid, bus.lsu_err}, 32'd0);
    bus.lsu_memop = 3'b010;

    // Reset while WAITing; the late response must be ignored.
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0010; bus.mem_req_ready = 1'b1;
    tick();
    bus.ifu_req_valid = 1'b0;
    tick();                                      // now in WAIT
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_mid");
    tick();
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("rst_mid.no_resp", {30'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 32'd0);
    chk("rst_mid.no_req",  {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rst_mid.rdata",   bus.ifu_rdata, 32'd0);
    tick();
    chk("rst_mid.no_resp2", {30'd0, bus.ifu_resp_valid, bus.lsu_resp_valid}, 32'd0);

    ifu_fetch("fetch1", 32'h8000_0010, 32'h0010_0073);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Single-outstanding arbiter that shares one memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle NPC core. It accepts a request from one side at a time and drives it onto a valid/ready memory port. It waits for the memory response, then returns a one-cycle response pulse to the owner. For LSU loads, it sign- or zero-extends the returned data according to MemOp, which moves load extension out of the datapath.

Parameters:
ADDR_W, 32, address width of all three ports
DATA_W, 32, data width (fixed 32 for RV32; other values unsupported)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
ifu_rdata  out  DATA_W  fetched instruction
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  load/store address
lsu_wen  in  1  1=store, 0=load
lsu_memop  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
lsu_wdata  in  DATA_W  store data, right-aligned
lsu_resp_valid  out  1  one-cycle pulse, load data valid or store done
lsu_rdata  out  DATA_W  extended load data (0 for stores)
lsu_err  out  1  pulses with lsu_resp_valid on an illegal memop
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable
mem_size  out  2  0=1B, 1=2B, 2=4B
mem_wdata  out  DATA_W  latched store data
mem_resp_valid  in  1  memory response
mem_rdata  in  DATA_W  right-aligned read data

Behaviour:
- Reset state: FSM in IDLE. Every output is 0, including ready signals, resp pulses, rdata, lsu_err and all mem_* outputs. Reset is asynchronous and takes effect mid-transaction; the in-flight access is abandoned with no response to either side.
- FSM states: IDLE, REQ, WAIT, RESP. Owner register: 0=IFU, 1=LSU.
- IDLE:
  - Grant is computed combinationally, and *_req_ready is asserted only to the granted side. Ready is never asserted outside IDLE.
  - Default grant is fixed priority, LSU over IFU.
  - On a handshake, latch addr, wen, size, wdata and memop, and set owner.
  - A legal request moves to REQ. IFU requests always use size 2 and wen 0.
- Illegal LSU memop (011, 110, 111): the request is accepted, but no memory access is made. Go directly to RESP with lsu_rdata=0 and lsu_err=1.
- REQ:
  - mem_req_valid=1, and the mem_* outputs are held stable until mem_req_ready.
  - On handshake, go to WAIT.
  - mem_resp_valid is ignored in REQ.
- WAIT:
  - On mem_resp_valid, latch the extended data and go to RESP.
  - Extension rules: b sign-extends bit 7, bu zero-extends [7:0], h sign-extends bit 15, hu zero-extends [15:0], w passes through.
  - Upper bits of mem_rdata are masked regardless of what memory drives.
  - Stores and IFU fetches latch raw data; the store response data is forced to 0.
- RESP:
  - The owner's resp_valid is high for exactly one cycle with its rdata.
  - There is no response backpressure.
  - Next state is IDLE.
- rdata outputs hold their last value between pulses.
- Minimum latency: accept at cycle N, mem_req_valid at N+1. With ready at N+1 and resp at N+2, resp_valid occurs at N+3. The next accept is possible at N+4.
- Only one transaction is outstanding. A mem_resp_valid seen in IDLE or REQ is dropped.
- Requesters hold valid and payload until ready; the arbiter does not re-sample the payload after acceptance.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: round-robin grant.
  - A last-grant bit is updated on every accepted request.
  - When both sides are valid in IDLE, the side not granted last wins.
  - The bit resets to "LSU last", so IFU wins the first tie.
  - A single requester always wins.
- Undefined: fixed LSU priority, and no last-grant register is present.

Test Plan:
- IFU fetch at 0x80000000, mem_req_ready=1, memory responds 0x00000413 one cycle later -> ifu_resp_valid pulses at accept+3 with ifu_rdata=0x00000413; mem_size=2, mem_wen=0.
- LSU lb at 0x80001003, mem_rdata=0xFFFFFF80 -> lsu_rdata=0xFFFFFF80. Repeat with lbu and mem_rdata=0x12345680 -> 0x00000080. Repeat with lh and mem_rdata=0x00008001 -> 0xFFFF8001.
- LSU sw 0xDEADBEEF at 0x80002000, mem_req_ready held low 3 cycles -> mem_* stable for all 4 REQ cycles; lsu_resp_valid pulses with lsu_rdata=0 after the response.
- IFU and LSU both valid continuously for 4 grants:
  - Default build: LSU, LSU, LSU, LSU.
  - With MEM_ARB_RR_EN: IFU, LSU, IFU, LSU.
  - In both builds, the losing side sees ready=0.
- LSU memop=011 -> accepted, no mem_req_valid, lsu_resp_valid and lsu_err at accept+1, lsu_rdata=0.
- Assert rst during WAIT, then deliver mem_resp_valid after release -> no resp pulse, all outputs 0, FSM in IDLE, next IFU request served normally.
